// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// the default bus widths used by the pipeline top.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        D_BUSY  = 2'd1,
        IF_BUSY = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Serialises MEM-stage data accesses and IF-stage fetches onto one external
// memory port, data first, holding each result until the pipeline advances.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ready,
    input  logic              i_d_read,
    input  logic              i_d_write,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic [DATA_W-1:0] i_d_wdata,
    output logic [DATA_W-1:0] o_d_rdata,
    output logic              o_d_ready,
    output logic              o_mem_read,
    output logic              o_mem_write,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    input  logic              i_mem_ready,
    output logic              o_stall
);

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic              r_if_done;
    logic              r_d_done;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_d_rdata;

    logic w_d_req;
    logic w_pend_d;
    logic w_pend_if;
    logic w_stall;
    logic w_issue_d;
    logic w_issue_if;
    logic w_complete;

    // A request stays pending until its done flag is set; done flags hold it off until the pipeline advances.
    assign w_d_req   = i_d_read | i_d_write;
    assign w_pend_d  = w_d_req & ~r_d_done;
    assign w_pend_if = i_if_req & ~r_if_done;
    assign w_stall   = (r_state != IDLE) | w_pend_d | w_pend_if;

    // State register.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and issue/complete decode; data wins because its instruction is older.
    always_comb begin
        w_state_nxt = r_state;
        w_issue_d   = 1'b0;
        w_issue_if  = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_d) begin
                    w_state_nxt = D_BUSY;
                    w_issue_d   = 1'b1;
                end else if (w_pend_if) begin
                    w_state_nxt = IF_BUSY;
                    w_issue_if  = 1'b1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            D_BUSY, IF_BUSY: begin
                if (i_mem_ready) begin
                    w_state_nxt = IDLE;
                    w_complete  = 1'b1;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // External bus command registers, held stable for the whole access.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
        end else if (w_issue_d) begin
            r_mem_addr  <= i_d_addr;
            r_mem_wdata <= i_d_wdata;
            r_mem_write <= i_d_write;
            r_mem_read  <= i_d_read & ~i_d_write;
        end else if (w_issue_if) begin
            r_mem_addr  <= i_if_addr;
            r_mem_read  <= 1'b1;
            r_mem_write <= 1'b0;
        end else if (w_complete) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
        end
    end

    // Done flags: set on completion, cleared whenever the pipeline is free to advance.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
        end else if (!w_stall) begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
        end else if (w_complete) begin
            if (r_state == D_BUSY) begin
                r_d_done <= 1'b1;
            end
            if (r_state == IF_BUSY) begin
                r_if_done <= 1'b1;
            end
        end
    end

    // Result capture; a store completes without touching the load data register.
    always_ff @(posedge clk) begin
        if (!i_rst) begin
            r_if_rdata <= {DATA_W{1'b0}};
            r_d_rdata  <= {DATA_W{1'b0}};
        end else if (w_complete) begin
            if ((r_state == D_BUSY) && r_mem_read) begin
                r_d_rdata <= i_mem_rdata;
            end
            if (r_state == IF_BUSY) begin
                r_if_rdata <= i_mem_rdata;
            end
        end
    end

    assign o_mem_read  = r_mem_read;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_rdata  = r_if_rdata;
    assign o_d_rdata   = r_d_rdata;
    assign o_if_ready  = r_if_done;
    assign o_d_ready   = r_d_done;
    assign o_stall     = w_stall;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: the bench plays the memory and
// checks each access at transaction level against the expected sequence.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic [31:0] o_if_rdata;
    logic        o_if_ready;
    logic        i_d_read;
    logic        i_d_write;
    logic [31:0] i_d_addr;
    logic [31:0] i_d_wdata;
    logic [31:0] o_d_rdata;
    logic        o_d_ready;
    logic        o_mem_read;
    logic        o_mem_write;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ready;
    logic        o_stall;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_d_rdata  = 32'h0;
    logic [31:0] exp_if_rdata = 32'h0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr),
        .o_if_rdata(o_if_rdata), .o_if_ready(o_if_ready),
        .i_d_read(i_d_read), .i_d_write(i_d_write),
        .i_d_addr(i_d_addr), .i_d_wdata(i_d_wdata),
        .o_d_rdata(o_d_rdata), .o_d_ready(o_d_ready),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_ready(i_mem_ready),
        .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    // One request group: optional data access plus optional fetch; the bench answers as memory.
    task automatic run_txn(input string name, input logic dr, input logic dw, input logic fe,
                           input logic [31:0] da, input logic [31:0] wd, input logic [31:0] ia,
                           input int ld, input int li, input logic [31:0] rd, input logic [31:0] ri);
        logic        e_rd [2];
        logic        e_wr [2];
        logic [31:0] e_ad [2];
        logic [31:0] e_wd [2];
        int          e_lat[2];
        logic [31:0] e_rdat[2];
        int ne, idx, cnt, cyc, stall_cnt, exp_stall;
        logic busy, pulsed;
        logic c_rd, c_wr;
        logic [31:0] c_ad, c_wd;
        ne = 0; exp_stall = 0;
        if (dr | dw) begin
            e_rd[ne] = dr & ~dw; e_wr[ne] = dw; e_ad[ne] = da; e_wd[ne] = wd;
            e_lat[ne] = ld; e_rdat[ne] = rd; exp_stall += 1 + ld; ne++;
        end
        if (fe) begin
            e_rd[ne] = 1'b1; e_wr[ne] = 1'b0; e_ad[ne] = ia; e_wd[ne] = 32'h0;
            e_lat[ne] = li; e_rdat[ne] = ri; exp_stall += 1 + li; ne++;
        end
        @(negedge clk);
        i_d_read = dr; i_d_write = dw; i_d_addr = da; i_d_wdata = wd;
        i_if_req = fe; i_if_addr = ia; i_mem_ready = 1'b0;
        #1;
        idx = 0; cnt = 0; cyc = 0; stall_cnt = 0; busy = 1'b0; pulsed = 1'b0;
        c_rd = 1'b0; c_wr = 1'b0; c_ad = 32'h0; c_wd = 32'h0;
        while (o_stall && cyc < 200) begin
            stall_cnt++;
            if (pulsed) begin
                n_tests++;
                if ((o_mem_read | o_mem_write) !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s bus_release: rd=%b wr=%b, required both 0", name, o_mem_read, o_mem_write);
                end
                pulsed = 1'b0; busy = 1'b0;
            end else if (o_mem_read | o_mem_write) begin
                if (!busy) begin
                    n_tests++;
                    if (cyc == 0 || idx >= ne) begin
                        n_fail++;
                        $display("FAIL %s cmd_unexpected: cycle %0d issued %0d of %0d", name, cyc, idx + 1, ne);
                        break;
                    end
                    if (o_mem_read !== e_rd[idx] || o_mem_write !== e_wr[idx] || o_mem_addr !== e_ad[idx]
                        || (e_wr[idx] && o_mem_wdata !== e_wd[idx])) begin
                        n_fail++;
                        $display("FAIL %s cmd%0d: rd=%b wr=%b addr=%h wd=%h, required rd=%b wr=%b addr=%h wd=%h",
                                 name, idx, o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata,
                                 e_rd[idx], e_wr[idx], e_ad[idx], e_wd[idx]);
                    end
                    busy = 1'b1; cnt = 0;
                    c_rd = o_mem_read; c_wr = o_mem_write; c_ad = o_mem_addr; c_wd = o_mem_wdata;
                end else begin
                    n_tests++;
                    if (o_mem_read !== c_rd || o_mem_write !== c_wr || o_mem_addr !== c_ad || o_mem_wdata !== c_wd) begin
                        n_fail++;
                        $display("FAIL %s cmd_hold: addr=%h rd=%b wr=%b, required addr=%h rd=%b wr=%b",
                                 name, o_mem_addr, o_mem_read, o_mem_write, c_ad, c_rd, c_wr);
                    end
                end
                cnt++;
                if (cnt == e_lat[idx]) begin
                    i_mem_ready = 1'b1; i_mem_rdata = e_rdat[idx]; pulsed = 1'b1; idx++;
                end
            end
            @(negedge clk);
            i_mem_ready = 1'b0; i_mem_rdata = $urandom;
            #1;
            cyc++;
        end
        if (dr & ~dw) exp_d_rdata = rd;
        if (fe) exp_if_rdata = ri;
        n_tests++;
        if (cyc >= 200 || idx != ne) begin
            n_fail++;
            $display("FAIL %s served: %0d accesses in %0d cycles, required %0d", name, idx, cyc, ne);
        end
        n_tests++;
        if (stall_cnt != exp_stall) begin
            n_fail++;
            $display("FAIL %s stall_cycles: %0d, required %0d", name, stall_cnt, exp_stall);
        end
        n_tests++;
        if (o_d_ready !== (dr | dw) || o_if_ready !== fe || o_mem_read !== 1'b0 || o_mem_write !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_flags: d=%b if=%b rd=%b wr=%b, required d=%b if=%b bus idle",
                     name, o_d_ready, o_if_ready, o_mem_read, o_mem_write, dr | dw, fe);
        end
        n_tests++;
        if (o_d_rdata !== exp_d_rdata || o_if_rdata !== exp_if_rdata) begin
            n_fail++;
            $display("FAIL %s rdata: d=%h if=%h, required d=%h if=%h", name, o_d_rdata, o_if_rdata, exp_d_rdata, exp_if_rdata);
        end
        // Pipeline advances: requests drop, flags must clear, results persist.
        i_d_read = 1'b0; i_d_write = 1'b0; i_if_req = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (o_d_ready !== 1'b0 || o_if_ready !== 1'b0 || o_stall !== 1'b0
            || o_d_rdata !== exp_d_rdata || o_if_rdata !== exp_if_rdata) begin
            n_fail++;
            $display("FAIL %s advance: d_rdy=%b if_rdy=%b stall=%b d=%h if=%h, required 0 0 0 %h %h",
                     name, o_d_ready, o_if_ready, o_stall, o_d_rdata, o_if_rdata, exp_d_rdata, exp_if_rdata);
        end
    endtask

    task automatic test_reset();
        int guard;
        i_rst = 1'b0; i_if_req = 1'b0; i_if_addr = 32'h0; i_d_read = 1'b0; i_d_write = 1'b0;
        i_d_addr = 32'h0; i_d_wdata = 32'h0; i_mem_rdata = 32'h0; i_mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (o_mem_read !== 1'b0 || o_mem_write !== 1'b0 || o_mem_addr !== 32'h0 || o_mem_wdata !== 32'h0
            || o_if_rdata !== 32'h0 || o_d_rdata !== 32'h0 || o_if_ready !== 1'b0 || o_d_ready !== 1'b0
            || o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: rd=%b wr=%b addr=%h stall=%b rdy=%b%b, required all zero",
                     o_mem_read, o_mem_write, o_mem_addr, o_stall, o_if_ready, o_d_ready);
        end
        i_rst = 1'b1;
        i_if_req = 1'b1; i_if_addr = 32'h100;
        guard = 0;
        while (!o_mem_read && guard < 10) begin
            @(negedge clk); #1; guard++;
        end
        n_tests++;
        if (o_mem_read !== 1'b1 || o_mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL reset_fetch_issue: rd=%b addr=%h, required 1 00000100", o_mem_read, o_mem_addr);
        end
        i_rst = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (o_mem_read !== 1'b0 || o_if_ready !== 1'b0 || o_stall !== 1'b1 || o_mem_addr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_txn: rd=%b if_rdy=%b stall=%b addr=%h, required 0 0 1 0",
                     o_mem_read, o_if_ready, o_stall, o_mem_addr);
        end
        i_rst = 1'b1; i_if_req = 1'b0;
        #1;
        n_tests++;
        if (o_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_stall: %b, required 0", o_stall);
        end
        exp_d_rdata = 32'h0; exp_if_rdata = 32'h0;
    endtask

    task automatic test_fetch_only();
        run_txn("fetch_only", 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h40, 0, 3, 32'h0, 32'hDEADBEEF);
    endtask

    task automatic test_simultaneous();
        run_txn("simultaneous", 1'b1, 1'b0, 1'b1, 32'h200, 32'h0, 32'h44, 2, 2, 32'hCAFEF00D, 32'h13579BDF);
    endtask

    task automatic test_store();
        run_txn("store", 1'b0, 1'b1, 1'b0, 32'h300, 32'h12345678, 32'h0, 3, 0, 32'hBADBAD00, 32'h0);
    endtask

    task automatic test_read_write_both();
        run_txn("read_write_both", 1'b1, 1'b1, 1'b0, 32'h10, 32'hA5A5A5A5, 32'h0, 1, 0, 32'h0F0F0F0F, 32'h0);
    endtask

    task automatic test_spurious_ready();
        @(negedge clk);
        i_mem_ready = 1'b1; i_mem_rdata = 32'hFFFF0000;
        @(negedge clk);
        i_mem_ready = 1'b0;
        #1;
        n_tests++;
        if (o_stall !== 1'b0 || o_d_ready !== 1'b0 || o_if_ready !== 1'b0 || o_mem_read !== 1'b0
            || o_mem_write !== 1'b0 || o_d_rdata !== exp_d_rdata || o_if_rdata !== exp_if_rdata) begin
            n_fail++;
            $display("FAIL spurious_ready: stall=%b rdy=%b%b d=%h if=%h, required 0 00 %h %h",
                     o_stall, o_d_ready, o_if_ready, o_d_rdata, o_if_rdata, exp_d_rdata, exp_if_rdata);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            logic dr, dw, fe;
            dr = 1'($urandom); dw = 1'($urandom); fe = 1'($urandom);
            if (!(dr | dw | fe)) fe = 1'b1;
            run_txn("random", dr, dw, fe, $urandom, $urandom, $urandom,
                    int'($urandom_range(1, 5)), int'($urandom_range(1, 5)), $urandom, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_store();
        test_read_write_both();
        test_spurious_ready();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single external memory port (mem_read/mem_write/mem_addr/mem_wdata/mem_rdata/mem_ready) between the IF-stage fetch and the MEM-stage data access of the 5-stage pipeline.
- Serialises the two requests, data first, and drives one pipeline-wide stall.
- Holds each served result until the pipeline advances, so no request is issued twice.

Parameters:
ADDR_W, 32, memory address width
DATA_W, 32, memory data width

Ports:
clk  in  1  clock, rising edge
i_rst  in  1  reset, synchronous, active-low
i_if_req  in  1  IF stage requests an instruction read
i_if_addr  in  ADDR_W  fetch address (PC)
o_if_rdata  out  DATA_W  fetched instruction, registered
o_if_ready  out  1  fetch result valid (level)
i_d_read  in  1  MEM stage load request
i_d_write  in  1  MEM stage store request
i_d_addr  in  ADDR_W  data address
i_d_wdata  in  DATA_W  store data
o_d_rdata  out  DATA_W  load data, registered
o_d_ready  out  1  data access complete (level)
o_mem_read  out  1  external read command, registered
o_mem_write  out  1  external write command, registered
o_mem_addr  out  ADDR_W  external address, registered
o_mem_wdata  out  DATA_W  external write data, registered
i_mem_rdata  in  DATA_W  external read data
i_mem_ready  in  1  external access complete, 1-cycle pulse
o_stall  out  1  freeze PC and all pipeline registers

Behaviour:
- Reset: when i_rst=0 at a clock edge:
  - state=IDLE
  - every output register=0: o_mem_*, o_if_rdata, o_d_rdata
  - done flags if_done=d_done=0, so o_if_ready=o_d_ready=0
  - This applies mid-transaction too. The bus is abandoned and the memory model must tolerate it.
- Request and pending terms:
  - d_req = i_d_read|i_d_write
  - pend_d = d_req & ~d_done
  - pend_if = i_if_req & ~if_done
- o_stall (combinational) = (state!=IDLE) | pend_d | pend_if.
- FSM states: IDLE, D_BUSY, IF_BUSY.
- IDLE:
  - If pend_d: go to D_BUSY. Register o_mem_addr=i_d_addr and o_mem_wdata=i_d_wdata. Set o_mem_write=i_d_write; set o_mem_read=i_d_read&~i_d_write (write wins if both are set).
  - Else if pend_if: go to IF_BUSY. Set o_mem_read=1 and o_mem_addr=i_if_addr.
  - Data has fixed priority because the older instruction must complete first.
  - i_mem_ready is ignored while in IDLE.
- D_BUSY / IF_BUSY:
  - Hold all o_mem_* stable until i_mem_ready=1.
  - On that edge:
    - clear o_mem_read/o_mem_write and return to IDLE
    - set the matching done flag
    - capture i_mem_rdata into o_d_rdata or o_if_rdata (for a store, o_d_rdata is unchanged)
- Latency:
  - request seen in IDLE at cycle 0, command on bus at cycle 1
  - i_mem_ready at cycle k≥1, done flag and rdata valid at cycle k+1
  - minimum 2 cycles per access; both requests pending costs data + fetch serially
- Done flags clear on any edge where o_stall=0 (the pipeline advances). rdata registers keep their value.
- Requests are sampled only in IDLE. A request deasserted during BUSY still completes and sets its done flag; the result is discarded when the flags clear.
- When both if_done and d_done are set, or no request is pending, o_stall=0.

Decomposition:
- Shared package holds:
  - state enum {IDLE, D_BUSY, IF_BUSY}, 2 bits
  - ADDR_W and DATA_W defaults shared with the pipeline top
- No sub-module. The FSM, request mux and two result registers form one unit of about 150–200 lines.

Test Plan:
1. Reset mid-transaction: fetch of 0x100 in IF_BUSY, i_rst=0 for one cycle. Next cycle: state IDLE, o_mem_read=0, o_if_ready=0, o_stall follows pend_if.
2. Fetch only: i_if_req=1, addr=0x40, memory answers 0xDEADBEEF with i_mem_ready on cycle 3.
   - o_mem_read=1 with addr 0x40 on cycles 1–3
   - o_if_ready=1 and o_if_rdata=0xDEADBEEF on cycle 4
   - o_stall=1 on cycles 0–3, 0 on cycle 4
   - flags clear on cycle 5
3. Simultaneous: load 0x200 and fetch 0x44 at cycle 0, each memory latency 2. Load issued first; fetch issued the cycle after load completes; o_stall stays 1 until both done flags are set; no address is issued twice.
4. Store: i_d_write=1, addr 0x300, wdata 0x12345678. o_mem_write=1 with those values held until i_mem_ready; o_d_ready=1 afterwards; o_d_rdata is unchanged.
5. Read+write both set: i_d_read=i_d_write=1, addr 0x10. Only o_mem_write=1; o_mem_read stays 0.
6. Spurious i_mem_ready pulse in IDLE with no request: no state change; o_stall=0; done flags and rdata are unchanged.
